// File: rtl/seat_pkg.sv
// Shared types for the seat-access path: seat states, kiosk ops, response codes, arbiter FSM states.
// Pure declarations; no logic, latency or backpressure of its own.
package seat_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    OCCUPIED = 2'b01,
    AWAY     = 2'b10,
    BANNED   = 2'b11
  } seat_state_t;

  typedef enum logic [1:0] {
    RESERVE = 2'b00,
    RELEASE = 2'b01,
    EXTEND  = 2'b10,
    QUERY   = 2'b11
  } seat_op_t;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    BUSY    = 2'b01,
    DENIED  = 2'b10,
    INVALID = 2'b11
  } resp_status_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_RESP = 2'b11
  } arb_state_t;

  localparam int MINUTES_PER_DAY = 1440;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping; one-hot grant plus its index.
// Latency: purely combinational. Backpressure: none; the pointer register lives in the parent.
// Requesters not picked simply stay pending.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = IW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seat_access_arbiter.sv
// Round-robin owner of the single seat-memory port: grant, read, rule check, optional write, respond.
// Latency: req_ready to resp_valid is 3 cycles; one request per 4 cycles at most.
// Backpressure: losers keep req_valid high until their one-cycle req_ready; ADMIN_PRIORITY_EN gives req 0 precedence.
module seat_access_arbiter
  import seat_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_SEATS = 32,
  parameter  int SEAT_W    = 5,
  parameter  int STU_W     = 32,
  parameter  int TIME_W    = 11,
  parameter  int DUR_MIN   = 120,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [STU_W*NUM_REQ-1:0]   req_student,
  input  logic [SEAT_W*NUM_REQ-1:0]  req_seat,
  input  logic [TIME_W-1:0]          now_time,
  output logic [SEAT_W-1:0]          mem_rd_seat,
  input  logic [1:0]                 mem_rd_state,
  input  logic [STU_W-1:0]           mem_rd_owner,
  output logic                       mem_we,
  output logic [SEAT_W-1:0]          mem_wr_seat,
  output logic [1:0]                 mem_wr_state,
  output logic [STU_W-1:0]           mem_wr_owner,
  output logic [TIME_W-1:0]          mem_wr_limit,
  output logic                       resp_valid,
  output logic [IDW-1:0]             resp_id,
  output logic [1:0]                 resp_status,
  output logic [1:0]                 resp_state
);

  arb_state_t   state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  seat_op_t     op_q, op_d;
  logic [STU_W-1:0] stu_q, stu_d;
  logic [SEAT_W-1:0] seat_q, seat_d;
  resp_status_t status_q, status_d;
  seat_state_t  rd_state_q, rd_state_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;

  logic [NUM_REQ-1:0] win_grant;
  logic [IDW-1:0]     win_idx;
  logic               win_admin;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
`ifdef ADMIN_PRIORITY_EN
    win_admin = req_valid[0];
`else
    win_admin = 1'b0;
`endif
    if (win_admin) begin
      win_grant = NUM_REQ'(1);
      win_idx   = '0;
    end else begin
      win_grant = arb_grant;
      win_idx   = arb_idx;
    end
  end

  // Rule evaluation for the EXEC cycle, using the registered memory read data.
  seat_state_t       rd_state;
  logic              seat_bad;
  logic              owner_match;
  logic              admin_rel;
  logic [TIME_W:0]   lim_sum;
  logic [TIME_W-1:0] lim_new;
  logic              wr_en;
  seat_state_t       wr_state;
  logic [STU_W-1:0]  wr_owner;
  logic [TIME_W-1:0] wr_limit;
  resp_status_t      exec_status;

  always_comb begin
    rd_state    = seat_state_t'(mem_rd_state);
    seat_bad    = ({1'b0, seat_q} >= (SEAT_W+1)'(NUM_SEATS));
    owner_match = (mem_rd_owner == stu_q);
`ifdef ADMIN_PRIORITY_EN
    admin_rel   = (id_q == '0) && (op_q == RELEASE);
`else
    admin_rel   = 1'b0;
`endif
    lim_sum = {1'b0, now_time} + (TIME_W+1)'(DUR_MIN);
    if (lim_sum >= (TIME_W+1)'(MINUTES_PER_DAY)) begin
      lim_new = TIME_W'(lim_sum - (TIME_W+1)'(MINUTES_PER_DAY));
    end else begin
      lim_new = TIME_W'(lim_sum);
    end

    wr_en       = 1'b0;
    wr_state    = rd_state;
    wr_owner    = mem_rd_owner;
    wr_limit    = '0;
    exec_status = OK;

    if (seat_bad) begin
      exec_status = INVALID;
    end else if (admin_rel) begin
      if (rd_state != FREE) begin
        wr_en    = 1'b1;
        wr_state = FREE;
        wr_owner = '0;
      end else begin
        exec_status = DENIED;
      end
    end else if (rd_state == BANNED && op_q != QUERY) begin
      exec_status = DENIED;
    end else begin
      case (op_q)
        RESERVE: begin
          if (rd_state == FREE) begin
            wr_en    = 1'b1;
            wr_state = OCCUPIED;
            wr_owner = stu_q;
            wr_limit = lim_new;
          end else begin
            exec_status = BUSY;
          end
        end
        RELEASE: begin
          if (owner_match && (rd_state == OCCUPIED || rd_state == AWAY)) begin
            wr_en    = 1'b1;
            wr_state = FREE;
            wr_owner = '0;
          end else begin
            exec_status = DENIED;
          end
        end
        EXTEND: begin
          if (owner_match && rd_state == OCCUPIED) begin
            wr_en    = 1'b1;
            wr_state = OCCUPIED;
            wr_owner = stu_q;
            wr_limit = lim_new;
          end else begin
            exec_status = DENIED;
          end
        end
        default: exec_status = OK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      op_q       <= RESERVE;
      stu_q      <= '0;
      seat_q     <= '0;
      status_q   <= OK;
      rd_state_q <= FREE;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      stu_q      <= stu_d;
      seat_q     <= seat_d;
      status_q   <= status_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    stu_d      = stu_q;
    seat_d     = seat_q;
    status_d   = status_q;
    rd_state_d = rd_state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_READ;
          id_d    = win_idx;
          op_d    = seat_op_t'(req_op[win_idx*2 +: 2]);
          stu_d   = req_student[win_idx*STU_W +: STU_W];
          seat_d  = req_seat[win_idx*SEAT_W +: SEAT_W];
          // Admin grants leave the rotation where it was.
          if (!win_admin) begin
            rr_ptr_d = (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          end
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d    = ST_RESP;
        status_d   = exec_status;
        rd_state_d = seat_bad ? FREE : rd_state;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while rst_n is asserted so an interrupted EXEC never writes.
  always_comb begin
    req_ready    = '0;
    mem_rd_seat  = '0;
    mem_we       = 1'b0;
    mem_wr_seat  = '0;
    mem_wr_state = '0;
    mem_wr_owner = '0;
    mem_wr_limit = '0;
    resp_valid   = 1'b0;
    resp_id      = '0;
    resp_status  = '0;
    resp_state   = '0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: req_ready = arb_any ? win_grant : '0;
        ST_READ: mem_rd_seat = seat_q;
        ST_EXEC: begin
          if (wr_en) begin
            mem_we       = 1'b1;
            mem_wr_seat  = seat_q;
            mem_wr_state = wr_state;
            mem_wr_owner = wr_owner;
            mem_wr_limit = wr_limit;
          end
        end
        default: begin
          resp_valid  = 1'b1;
          resp_id     = id_q;
          resp_status = status_q;
          resp_state  = rd_state_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seat_access_arbiter.sv
// Directed bench for seat_access_arbiter with a behavioural seat memory and response/write scoreboards.
// ADMIN_PRIORITY_EN adds the admin-console steps when the design is built with it.
module tb_seat_access_arbiter;
  import seat_pkg::*;

  localparam int NR = 4;
  localparam int SW = 6;
  localparam int UW = 32;
  localparam int TW = 11;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [2*NR-1:0]   req_op;
  logic [UW*NR-1:0]  req_student;
  logic [SW*NR-1:0]  req_seat;
  logic [TW-1:0]     now_time;
  logic [SW-1:0]     mem_rd_seat;
  logic [1:0]        mem_rd_state;
  logic [UW-1:0]     mem_rd_owner;
  logic              mem_we;
  logic [SW-1:0]     mem_wr_seat;
  logic [1:0]        mem_wr_state;
  logic [UW-1:0]     mem_wr_owner;
  logic [TW-1:0]     mem_wr_limit;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [1:0]        resp_status;
  logic [1:0]        resp_state;

  seat_access_arbiter #(
    .NUM_REQ(NR), .NUM_SEATS(32), .SEAT_W(SW), .STU_W(UW), .TIME_W(TW), .DUR_MIN(120)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_student(req_student), .req_seat(req_seat), .now_time(now_time),
    .mem_rd_seat(mem_rd_seat), .mem_rd_state(mem_rd_state), .mem_rd_owner(mem_rd_owner),
    .mem_we(mem_we), .mem_wr_seat(mem_wr_seat), .mem_wr_state(mem_wr_state),
    .mem_wr_owner(mem_wr_owner), .mem_wr_limit(mem_wr_limit),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status), .resp_state(resp_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Seat memory with a registered read port; presets go through the same process.
  logic [1:0]    m_state [64];
  logic [UW-1:0] m_owner [64];
  logic [TW-1:0] m_limit [64];
  logic          pre_we;
  logic [SW-1:0] pre_seat;
  logic [1:0]    pre_state;

  always @(posedge clk) begin
    mem_rd_state <= m_state[mem_rd_seat];
    mem_rd_owner <= m_owner[mem_rd_seat];
    if (pre_we) begin
      m_state[pre_seat] = pre_state;
      m_owner[pre_seat] = '0;
      m_limit[pre_seat] = '0;
    end
    if (mem_we) begin
      m_state[mem_wr_seat] = mem_wr_state;
      m_owner[mem_wr_seat] = mem_wr_owner;
      m_limit[mem_wr_seat] = mem_wr_limit;
    end
  end

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    status;
    logic [1:0]    state;
    logic          chk_st;
  } rexp_t;

  typedef struct packed {
    logic [SW-1:0] seat;
    logic [1:0]    state;
    logic [UW-1:0] owner;
    logic [TW-1:0] limit;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int    gq[$];
  rexp_t re;
  wexp_t we;
  int    g;

  always @(negedge clk) begin
    cyc++;
    if (req_ready != '0) begin
      chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      gq.push_back(cyc);
    end
    if (resp_valid) begin
      chk("resp_pending", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        re = rq.pop_front();
        chk("resp_id", 64'(resp_id), 64'(re.id));
        chk("resp_status", 64'(resp_status), 64'(re.status));
        if (re.chk_st) chk("resp_state", 64'(resp_state), 64'(re.state));
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("resp_latency", 64'(cyc - g), 64'd3);
        end
      end
    end
    if (mem_we) begin
      chk("write_pending", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        chk("wr_seat", 64'(mem_wr_seat), 64'(we.seat));
        chk("wr_state", 64'(mem_wr_state), 64'(we.state));
        chk("wr_owner", 64'(mem_wr_owner), 64'(we.owner));
        chk("wr_limit", 64'(mem_wr_limit), 64'(we.limit));
      end
    end
  end

  task automatic preset(input logic [SW-1:0] seat, input logic [1:0] st);
    @(posedge clk); #1;
    pre_seat = seat; pre_state = st; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_resp(input int id, input logic [1:0] status, input logic [1:0] st, input logic c);
    rq.push_back('{id: IW'(id), status: status, state: st, chk_st: c});
  endtask

  task automatic push_wr(input int seat, input logic [1:0] st, input int owner, input int limit);
    wq.push_back('{seat: SW'(seat), state: st, owner: UW'(owner), limit: TW'(limit)});
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input int stu, input int seat);
    req_op[2*r +: 2]       = op;
    req_student[UW*r +: UW] = UW'(stu);
    req_seat[SW*r +: SW]   = SW'(seat);
    req_valid[r]           = 1'b1;
  endtask

  task automatic wait_grant(input int r);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    chk($sformatf("grant_req%0d", r), 64'(got), 64'd1);
  endtask

  task automatic drop(input int r);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq.size() == 0) done = 1'b1;
    end
    chk("drain", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int r, input logic [1:0] op, input int stu, input int seat);
    set_req(r, op, stu, seat);
    wait_grant(r);
    drop(r);
    wait_idle();
  endtask

  time t_prev;
  time t_now;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_student = '0; req_seat = '0;
    now_time = 11'd600; pre_we = 1'b0; pre_seat = '0; pre_state = '0;
    preset(3, FREE);
    preset(4, FREE);
    preset(7, FREE);
    preset(9, BANNED);
    preset(10, FREE);
    @(negedge clk);
    chk("rst_outputs_a", 64'({req_ready, mem_we, resp_valid, resp_id, resp_status, resp_state,
                              mem_rd_seat, mem_wr_seat, mem_wr_state}), 64'd0);
    chk("rst_outputs_b", 64'({mem_wr_owner, mem_wr_limit}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 64'({req_ready, mem_we, resp_valid, mem_rd_seat}), 64'd0);
    @(posedge clk); #1;

    // Round robin with every requester held valid.
    for (int r = 0; r < NR; r++) set_req(r, QUERY, 100 + r, 3);
    push_resp(0, OK, FREE, 1'b1);
    push_resp(1, OK, FREE, 1'b1);
    push_resp(2, OK, FREE, 1'b1);
    push_resp(3, OK, FREE, 1'b1);
    push_resp(0, OK, FREE, 1'b1);
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % NR);
      t_now = $time;
      if (k > 0) chk("rr_spacing", 64'(t_now - t_prev), 64'd40);
      t_prev = t_now;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reserve without and with midnight wrap.
    now_time = 11'd600;
    push_wr(3, OCCUPIED, 1001, 720);
    push_resp(0, OK, FREE, 1'b1);
    do_req(0, RESERVE, 1001, 3);
    chk("mem3_state", 64'(m_state[3]), 64'(OCCUPIED));
    chk("mem3_limit", 64'(m_limit[3]), 64'd720);

    now_time = 11'd1400;
    push_wr(4, OCCUPIED, 2002, 80);
    push_resp(2, OK, FREE, 1'b1);
    do_req(2, RESERVE, 2002, 4);

    // Two reservations of one seat: the later one sees the earlier write.
    now_time = 11'd600;
    push_resp(1, OK, FREE, 1'b1);
    push_wr(7, OCCUPIED, 3001, 720);
    push_resp(2, BUSY, OCCUPIED, 1'b1);
    set_req(1, RESERVE, 3001, 7);
    set_req(2, RESERVE, 3002, 7);
    wait_grant(1);
    drop(1);
    wait_grant(2);
    drop(2);
    wait_idle();
    chk("mem7_owner", 64'(m_owner[7]), 64'd3001);

    push_resp(3, DENIED, OCCUPIED, 1'b1);
    do_req(3, RELEASE, 9999, 3);

    now_time = 11'd1439;
    push_wr(3, OCCUPIED, 1001, 119);
    push_resp(0, OK, OCCUPIED, 1'b1);
    do_req(0, EXTEND, 1001, 3);

    push_resp(1, INVALID, FREE, 1'b0);
    do_req(1, RESERVE, 1234, 40);

    push_resp(2, DENIED, BANNED, 1'b1);
    do_req(2, RESERVE, 5555, 9);

    now_time = 11'd600;
    push_wr(7, FREE, 0, 0);
    push_resp(3, OK, OCCUPIED, 1'b1);
    do_req(3, RELEASE, 3001, 7);

    // Reset during EXEC abandons the request; the pointer (would be 3) returns to 0.
    set_req(2, RESERVE, 7777, 10);
    wait_grant(2);
    drop(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_a", 64'({req_ready, mem_we, resp_valid, resp_id, resp_status, resp_state,
                           mem_rd_seat, mem_wr_seat, mem_wr_state}), 64'd0);
    chk("rst_exec_b", 64'({mem_wr_owner, mem_wr_limit}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gq.delete();
    @(negedge clk);
    chk("rst_no_resp", 64'(resp_valid), 64'd0);
    chk("mem10_untouched", 64'(m_state[10]), 64'(FREE));
    @(posedge clk); #1;

    push_resp(1, OK, OCCUPIED, 1'b1);
    push_resp(3, OK, OCCUPIED, 1'b1);
    set_req(1, QUERY, 1, 3);
    set_req(3, QUERY, 3, 3);
    @(negedge clk);
    chk("ptr_after_reset", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_grant(3);
    drop(3);
    wait_idle();

    push_wr(10, OCCUPIED, 7777, 720);
    push_resp(2, OK, FREE, 1'b1);
    set_req(2, RESERVE, 7777, 10);
    @(negedge clk);
    chk("grant_immediate", 64'(req_ready), 64'b0100);
    drop(2);
    wait_idle();

`ifdef ADMIN_PRIORITY_EN
    push_resp(0, OK, OCCUPIED, 1'b1);
    push_resp(3, OK, OCCUPIED, 1'b1);
    set_req(0, QUERY, 0, 3);
    set_req(3, QUERY, 3, 3);
    @(negedge clk);
    chk("admin_first", 64'(req_ready), 64'b0001);
    drop(0);
    wait_grant(3);
    drop(3);
    wait_idle();

    push_wr(9, FREE, 0, 0);
    push_resp(0, OK, BANNED, 1'b1);
    do_req(0, RELEASE, 0, 9);
    chk("mem9_freed", 64'(m_state[9]), 64'(FREE));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
